// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the memory controller: FSM state encoding,
// word geometry and the alignment rule applied to incoming byte addresses.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int         WORD_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // A request is misaligned when any byte-offset bit inside the word is set.
  function automatic logic is_misaligned(input logic [1:0] low_bits);
    return (low_bits & ALIGN_MASK) != 2'b00;
  endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Core-to-memory bus: request side driven by the core (master),
// response side driven by the controller (slave).
interface mem_ctrl_if #(
  parameter int WIDTH = 32
);
  logic             memread;
  logic             memwrite;
  logic [WIDTH-1:0] adr;
  logic [WIDTH-1:0] writedata;
  logic [WIDTH-1:0] memdata;
  logic             ready;
  logic             rdvalid;
  logic             wrack;
  logic             err;

  modport master (
    output memread, memwrite, adr, writedata,
    input  memdata, ready, rdvalid, wrack, err
  );

  modport slave (
    input  memread, memwrite, adr, writedata,
    output memdata, ready, rdvalid, wrack, err
  );
endinterface

// File: rtl/mem_ctrl_spram.sv
// Word-wide single-port RAM: synchronous write, combinational read.
module spram #(
  parameter int WIDTH   = 32,
  parameter int ADRBITS = 8
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADRBITS-1:0] addr,
  input  logic [WIDTH-1:0]   wdata,
  output logic [WIDTH-1:0]   rdata
);

  logic [WIDTH-1:0] mem [2**ADRBITS];

  // Commit a write on the rising edge when enabled.
  // NOTE: the array deliberately has no reset; contents survive a controller
  // reset and a reset port here would stop it mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/mem_ctrl.sv
// Memory controller for the mips32 core: accepts one read or write at a time,
// inserts WAIT wait states, then responds with rdvalid/wrack for one cycle.
// Misaligned requests are dropped with a one-cycle err pulse.
module mem_ctrl #(
  parameter int WIDTH   = 32,
  parameter int ADRBITS = 8,
  parameter int WAIT    = 2
) (
  input  logic     clk,
  input  logic     reset,
  mem_ctrl_if.slave bus
);

  // The WAIT parameter shadows the state literal of the same name, so the
  // wait state is always written as mem_ctrl_pkg::WAIT in this module.
  import mem_ctrl_pkg::state_t;
  import mem_ctrl_pkg::IDLE;
  import mem_ctrl_pkg::RESP;
  import mem_ctrl_pkg::WORD_BYTES;
  import mem_ctrl_pkg::is_misaligned;

  localparam int BYTE_BITS = $clog2(WORD_BYTES);

  state_t             state_q, state_d;
  logic [3:0]         cnt_q;
  logic [ADRBITS-1:0] idx_q;
  logic [WIDTH-1:0]   wdata_q;
  logic               is_write_q;
  logic [WIDTH-1:0]   memdata_q;
  logic               rdvalid_q, wrack_q, err_q;

  logic               accept, misaligned, take, op_write, going_resp, ram_we;
  logic [ADRBITS-1:0] ram_idx;
  logic [WIDTH-1:0]   ram_rdata;
  logic               unused_adr_bits;

  // Upper address bits only alias; they never select anything.
  assign unused_adr_bits = ^bus.adr[WIDTH-1:ADRBITS+BYTE_BITS];

  // Request qualification and RAM port steering.
  assign accept     = (state_q == IDLE) && (bus.memread || bus.memwrite);
  assign misaligned = is_misaligned(bus.adr[1:0]);
  assign take       = accept && !misaligned;
  // With WAIT==0 the response starts on the accept edge, before the capture
  // registers hold the request, so IDLE uses the live bus instead.
  assign op_write   = (state_q == IDLE) ? bus.memwrite : is_write_q;
  assign ram_idx    = (state_q == IDLE) ? bus.adr[ADRBITS+BYTE_BITS-1:BYTE_BITS] : idx_q;
  assign ram_we     = (state_q == RESP) && is_write_q;
  assign going_resp = (state_d == RESP);

  spram #(.WIDTH(WIDTH), .ADRBITS(ADRBITS)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  // Next-state decode.
  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:              if (take) state_d = (WAIT == 0) ? RESP : mem_ctrl_pkg::WAIT;
      mem_ctrl_pkg::WAIT: if (cnt_q == 4'd0) state_d = RESP;
      RESP:              state_d = IDLE;
      default:           state_d = IDLE;
    endcase
  end

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Wait counter, request capture and registered response outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q      <= '0;
      idx_q      <= '0;
      wdata_q    <= '0;
      is_write_q <= 1'b0;
      memdata_q  <= '0;
      rdvalid_q  <= 1'b0;
      wrack_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      err_q     <= accept && misaligned;
      rdvalid_q <= going_resp && !op_write;
      wrack_q   <= going_resp && op_write;
      if (going_resp && !op_write) memdata_q <= ram_rdata;
      if (take) begin
        idx_q      <= bus.adr[ADRBITS+BYTE_BITS-1:BYTE_BITS];
        wdata_q    <= bus.writedata;
        is_write_q <= bus.memwrite;
        cnt_q      <= 4'(WAIT > 0 ? WAIT - 1 : 0);
      end else if (state_q == mem_ctrl_pkg::WAIT && cnt_q != 4'd0) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  assign bus.ready   = (state_q == IDLE);
  assign bus.memdata = memdata_q;
  assign bus.rdvalid = rdvalid_q;
  assign bus.wrack   = wrack_q;
  assign bus.err     = err_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: a WAIT=2 and a WAIT=0 instance, directed
// scenarios plus randomized back-to-back traffic checked against a
// word-array model of memory and the response timing rules.
module tb_mem_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mem_ctrl_if #(.WIDTH(32)) bus2 ();
  mem_ctrl_if #(.WIDTH(32)) bus0 ();

  mem_ctrl #(.WIDTH(32), .ADRBITS(8), .WAIT(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2));
  mem_ctrl #(.WIDTH(32), .ADRBITS(8), .WAIT(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  int n_vec = 0;
  int n_err = 0;
  int cur   = 0;  // 0 selects the WAIT=2 instance, 1 the WAIT=0 instance

  // Reference model: memory words and the last completed read per instance.
  logic [31:0] mdl_mem [2][256];
  logic [31:0] mdl_md  [2];

  // {ready, rdvalid, wrack, err, memdata} of the selected instance.
  logic [35:0] obs;
  assign obs = (cur == 0) ? {bus2.ready, bus2.rdvalid, bus2.wrack, bus2.err, bus2.memdata}
                          : {bus0.ready, bus0.rdvalid, bus0.wrack, bus0.err, bus0.memdata};

  task automatic drive(input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (cur == 0) begin
      bus2.memread = rd; bus2.memwrite = wr; bus2.adr = a; bus2.writedata = d;
    end else begin
      bus0.memread = rd; bus0.memwrite = wr; bus0.adr = a; bus0.writedata = d;
    end
  endtask

  // One transaction, starting and ending at a falling edge. Bus inputs are
  // scrambled right after the accept edge to show the request was captured.
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input string name);
    int          lat   = (cur == 0) ? 3 : 1;
    bit          mis   = (a % 32'd4) != 0;
    int          idx   = int'((a / 32'd4) % 32'd256);
    bit          is_rd = rd && !wr;
    bit          last;
    logic [35:0] exp;
    drive(rd, wr, a, d);
    @(posedge clk); #1;
    if (mis) begin
      drive(1'b0, 1'b0, $urandom, $urandom);
      @(negedge clk);
      exp = {4'b1001, mdl_md[cur]};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s err-pulse: got %h want %h (ready,rdvalid,wrack,err|memdata)", name, obs, exp);
      end
      @(negedge clk);
      exp = {4'b1000, mdl_md[cur]};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s err-end: got %h want %h", name, obs, exp);
      end
    end else begin
      drive(1'($urandom), 1'($urandom), $urandom, $urandom);
      for (int k = 1; k <= lat; k++) begin
        @(negedge clk);
        last = (k == lat);
        if (last && is_rd) mdl_md[cur] = mdl_mem[cur][idx];
        exp = {1'b0, last && is_rd, last && wr, 1'b0, mdl_md[cur]};
        n_vec++;
        if (obs !== exp) begin
          n_err++;
          $display("FAIL %s busy-cycle%0d: got %h want %h", name, k, obs, exp);
        end
      end
      if (wr) mdl_mem[cur][idx] = d;
      @(negedge clk);
      exp = {4'b1000, mdl_md[cur]};
      n_vec++;
      if (obs !== exp) begin
        n_err++;
        $display("FAIL %s ready-return: got %h want %h", name, obs, exp);
      end
    end
    drive(1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    cur = 0; drive(1'b0, 1'b0, 32'h0, 32'h0);
    cur = 1; drive(1'b0, 1'b0, 32'h0, 32'h0);
    cur = 0;
    repeat (2) @(negedge clk);
    n_vec++;
    if (obs !== {4'b1000, 32'h0}) begin
      n_err++;
      $display("FAIL reset-wait2: got %h want %h", obs, {4'b1000, 32'h0});
    end
    n_vec++;
    if ({bus0.ready, bus0.rdvalid, bus0.wrack, bus0.err, bus0.memdata} !== {4'b1000, 32'h0}) begin
      n_err++;
      $display("FAIL reset-wait0: got %b%b%b%b %h want 1000 0", bus0.ready, bus0.rdvalid,
               bus0.wrack, bus0.err, bus0.memdata);
    end
    reset = 1'b0;
    mdl_md[0] = 32'h0;
    mdl_md[1] = 32'h0;
  endtask

  task automatic test_write_read();
    cur = 0;
    run_txn(1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, "write 0x10");
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, "read 0x10");
  endtask

  task automatic test_misaligned();
    cur = 0;
    run_txn(1'b1, 1'b0, 32'h0000_0013, 32'h0, "read 0x13");
    run_txn(1'b0, 1'b1, 32'h0000_0412, 32'h5555_AAAA, "write 0x412");
    run_txn(1'b1, 1'b0, 32'h0000_0010, 32'h0, "reread 0x10");
  endtask

  task automatic test_read_write_priority();
    cur = 0;
    run_txn(1'b1, 1'b1, 32'h0000_0020, 32'h1234_5678, "rd+wr 0x20");
    run_txn(1'b1, 1'b0, 32'h0000_0020, 32'h0, "read 0x20");
  endtask

  task automatic test_alias();
    cur = 0;
    run_txn(1'b0, 1'b1, 32'h0000_0404, 32'hA5A5_A5A5, "write 0x404");
    run_txn(1'b1, 1'b0, 32'h0000_0004, 32'h0, "read 0x004");
  endtask

  task automatic test_reset_mid_write();
    cur = 0;
    run_txn(1'b0, 1'b1, 32'h0000_0030, 32'h0, "write 0 to 0x30");
    drive(1'b0, 1'b1, 32'h0000_0030, 32'h0000_0001);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    mdl_md[0] = 32'h0;
    mdl_md[1] = 32'h0;
    n_vec++;
    if (obs !== {4'b1000, 32'h0}) begin
      n_err++;
      $display("FAIL reset-in-wait: got %h want %h", obs, {4'b1000, 32'h0});
    end
    @(negedge clk);
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (obs !== {4'b1000, 32'h0}) begin
        n_err++;
        $display("FAIL post-reset-idle%0d: got %h want %h", k, obs, {4'b1000, 32'h0});
      end
    end
    run_txn(1'b1, 1'b0, 32'h0000_0030, 32'h0, "read 0x30 after abort");
  endtask

  // Reset raised between clock edges during a read response must clear
  // everything without waiting for an edge.
  task automatic test_async_reset();
    cur = 0;
    run_txn(1'b0, 1'b1, 32'h0000_0040, 32'h1122_3344, "write 0x40");
    drive(1'b1, 1'b0, 32'h0000_0040, 32'h0);
    @(posedge clk); #1;
    drive(1'b0, 1'b0, 32'h0, 32'h0);
    repeat (3) @(negedge clk);
    n_vec++;
    if (obs !== {4'b0100, 32'h1122_3344}) begin
      n_err++;
      $display("FAIL resp-before-reset: got %h want %h", obs, {4'b0100, 32'h1122_3344});
    end
    #2 reset = 1'b1;
    #1;
    mdl_md[0] = 32'h0;
    mdl_md[1] = 32'h0;
    n_vec++;
    if (obs !== {4'b1000, 32'h0}) begin
      n_err++;
      $display("FAIL async-reset: got %h want %h", obs, {4'b1000, 32'h0});
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_wait0();
    cur = 1;
    run_txn(1'b0, 1'b1, 32'h0000_0008, 32'hCAFE_F00D, "w0 write 0x8");
    run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, "w0 read 0x8");
    run_txn(1'b1, 1'b0, 32'h0000_000A, 32'h0, "w0 read 0xA");
    run_txn(1'b1, 1'b1, 32'h0000_0408, 32'h0BAD_CAFE, "w0 rd+wr 0x408");
    run_txn(1'b1, 1'b0, 32'h0000_0008, 32'h0, "w0 read 0x8 again");
  endtask

  // Randomized back-to-back traffic over a small pool of words, with random
  // upper address bits (aliasing) and occasional misaligned requests.
  task automatic test_back_to_back(input int sel);
    logic [31:0] a;
    int          op;
    cur = sel;
    for (int i = 0; i < 16; i++) begin
      a = ($urandom & 32'hFFFF_FC00) | (32'(i) << 2);
      run_txn(1'b0, 1'b1, a, $urandom, "rand fill");
    end
    for (int i = 0; i < 48; i++) begin
      op = int'($urandom_range(0, 2));
      a  = ($urandom & 32'hFFFF_FC00) | (32'($urandom_range(0, 15)) << 2);
      if ($urandom_range(0, 7) == 0) a = a | 32'($urandom_range(1, 3));
      run_txn(op != 1, op != 0, a, $urandom, "rand op");
    end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_misaligned();
    test_read_write_priority();
    test_alias();
    test_reset_mid_write();
    test_async_reset();
    test_wait0();
    test_back_to_back(0);
    test_back_to_back(1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Single-port data/instruction memory controller sitting directly downstream of the mips32 core.
- Consumes the core's memread, memwrite, adr and writedata. Produces memdata plus a ready/valid handshake.
- Owns a word-addressed on-chip RAM with a configurable number of wait states, so the core can be stalled on slow memory.

Parameters:
- WIDTH, 32, data and address width.
- ADRBITS, 8, log2 of RAM depth in words (256 words).
- WAIT, 2, wait-state cycles inserted between accept and response (0 allowed, max 15).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  asynchronous, active-high reset.
- memread  input  1  read request.
- memwrite  input  1  write request.
- adr  input  WIDTH  byte address.
- writedata  input  WIDTH  write data.
- memdata  output  WIDTH  read data; holds the last completed read.
- ready  output  1  high when the controller can accept a request.
- rdvalid  output  1  one-cycle pulse: memdata updated this cycle.
- wrack  output  1  one-cycle pulse: write committed.
- err  output  1  one-cycle pulse: misaligned request dropped.

Behaviour:
- Reset (async, immediate): state IDLE, ready=1, memdata=0, rdvalid=0, wrack=0, err=0, wait counter=0. RAM contents are not cleared by reset.
- FSM states: IDLE, WAIT, RESP. ready = (state==IDLE), combinational from state.
- Accept: in IDLE, a request is accepted on a rising edge where memread|memwrite is high.
  - On accept, capture adr, writedata and the operation type.
  - memwrite has priority: if both memread and memwrite are high, a write is performed and no read occurs.
- Alignment check: if adr[1:0]!=0 at accept, the request is dropped.
  - err pulses for exactly one cycle (registered, the cycle after the edge).
  - State stays IDLE, no RAM write, memdata unchanged.
- Address decode: word index = adr[ADRBITS+1:2]. Upper address bits are ignored, so addresses alias modulo 4*2^ADRBITS bytes.
- Transitions:
  - IDLE->WAIT on an aligned accept when WAIT>0; the counter loads WAIT-1.
  - IDLE->RESP when WAIT==0.
  - WAIT: the counter decrements each cycle; WAIT->RESP when the counter==0.
  - RESP->IDLE unconditionally after one cycle.
- RESP cycle:
  - Read: memdata is loaded with RAM[index]. rdvalid=1 during this cycle.
  - Write: RAM[index] is written at the RESP->IDLE edge. wrack=1 during the RESP cycle.
- Latency: rdvalid/wrack assert WAIT+1 cycles after the accept edge. ready returns high the cycle after RESP. Back-to-back throughput is one request per WAIT+2 cycles.
- Requests presented while ready=0 are ignored, not queued; the core must hold its request until ready.
- Changing adr/writedata after accept has no effect on the in-flight transaction.
- Reset mid-transaction aborts it:
  - A pending write is not committed.
  - memdata returns to 0.
- Read-after-write to the same address in consecutive transactions returns the new data.

Decomposition:
- Package mem_ctrl_pkg holds:
  - State encoding constants: IDLE=2'd0, WAIT=2'd1, RESP=2'd2.
  - WORD_BYTES=4 and the alignment mask 2'b11.
- Sub-module spram (parameters WIDTH, ADRBITS): synchronous write-enable single-port RAM with combinational read and no reset. mem_ctrl contains the FSM, counter, capture registers and output registers.

Test Plan:
- Reset asserted mid-cycle with clk idle -> ready=1, memdata=0, rdvalid=wrack=err=0 immediately.
- WAIT=2:
  - Write 0xDEADBEEF to adr 0x10 -> wrack pulses 3 cycles after accept and ready drops for 3 cycles.
  - Then a read of 0x10 -> rdvalid pulses 3 cycles after accept with memdata=0xDEADBEEF.
- Read adr 0x13 -> err pulses one cycle, ready stays 1, memdata unchanged, no RAM change. Write to 0x412 behaves the same way.
- memread=memwrite=1, adr 0x20, writedata 0x12345678 -> wrack only, no rdvalid. A subsequent read of 0x20 returns 0x12345678.
- Aliasing: write 0xA5A5A5A5 to adr 0x404 with ADRBITS=8, then read 0x004 -> memdata=0xA5A5A5A5.
- Reset pulse during WAIT of a write of 0x1 to 0x30 (previous value 0x0) -> FSM is IDLE after reset, no wrack, and a read of 0x30 returns 0x0.
- WAIT=0 build: read accepted at edge n -> rdvalid at cycle n+1, ready low for exactly 1 cycle.
